// File: rtl/sha2_pkg.sv
// sha2_pkg: shared word types, small-sigma rotate/shift amounts and helper
// functions for the SHA-2 message schedule, plus the schedule FSM state type.
package sha2_pkg;

  typedef logic [31:0] sha256_word_t;
  typedef logic [63:0] sha512_word_t;

  // SHA-224/256 small-sigma amounts
  localparam int unsigned Sha256S0Rot0 = 32'd7;
  localparam int unsigned Sha256S0Rot1 = 32'd18;
  localparam int unsigned Sha256S0Shr  = 32'd3;
  localparam int unsigned Sha256S1Rot0 = 32'd17;
  localparam int unsigned Sha256S1Rot1 = 32'd19;
  localparam int unsigned Sha256S1Shr  = 32'd10;

  // SHA-384/512 small-sigma amounts
  localparam int unsigned Sha512S0Rot0 = 32'd1;
  localparam int unsigned Sha512S0Rot1 = 32'd8;
  localparam int unsigned Sha512S0Shr  = 32'd7;
  localparam int unsigned Sha512S1Rot0 = 32'd19;
  localparam int unsigned Sha512S1Rot1 = 32'd61;
  localparam int unsigned Sha512S1Shr  = 32'd6;

  typedef enum logic [0:0] {
    SchedIdle = 1'b0,
    SchedRun  = 1'b1
  } sched_state_e;

  function automatic sha256_word_t sha256_rotr(input sha256_word_t x, input int unsigned n);
    return (x >> n) | (x << (32'd32 - n));
  endfunction

  function automatic sha512_word_t sha512_rotr(input sha512_word_t x, input int unsigned n);
    return (x >> n) | (x << (32'd64 - n));
  endfunction

  function automatic sha256_word_t sha256_s0(input sha256_word_t x);
    return sha256_rotr(x, Sha256S0Rot0) ^ sha256_rotr(x, Sha256S0Rot1) ^ (x >> Sha256S0Shr);
  endfunction

  function automatic sha256_word_t sha256_s1(input sha256_word_t x);
    return sha256_rotr(x, Sha256S1Rot0) ^ sha256_rotr(x, Sha256S1Rot1) ^ (x >> Sha256S1Shr);
  endfunction

  function automatic sha512_word_t sha512_s0(input sha512_word_t x);
    return sha512_rotr(x, Sha512S0Rot0) ^ sha512_rotr(x, Sha512S0Rot1) ^ (x >> Sha512S0Shr);
  endfunction

  function automatic sha512_word_t sha512_s1(input sha512_word_t x);
    return sha512_rotr(x, Sha512S1Rot0) ^ sha512_rotr(x, Sha512S1Rot1) ^ (x >> Sha512S1Shr);
  endfunction

endpackage

// File: rtl/sha2_small_sigma.sv
// sha2_small_sigma: combinational SHA-2 small sigma. Sel=0 gives s0, Sel=1 gives s1;
// WordWidth=64 selects the SHA-384/512 amounts, otherwise SHA-224/256.
module sha2_small_sigma
  import sha2_pkg::*;
#(
  parameter int WordWidth = 32,
  parameter int Sel       = 0
) (
  input  logic [WordWidth-1:0] x_i,
  output logic [WordWidth-1:0] y_o
);

  if (WordWidth == 64) begin : g_sha512
    if (Sel == 0) begin : g_s0
      assign y_o = sha512_s0(x_i);
    end else begin : g_s1
      assign y_o = sha512_s1(x_i);
    end
  end else begin : g_sha256
    if (Sel == 0) begin : g_s0
      assign y_o = sha256_s0(x_i);
    end else begin : g_s1
      assign y_o = sha256_s1(x_i);
    end
  end

endmodule

// File: rtl/sha2_msg_schedule.sv
// sha2_msg_schedule: SHA-2 message-schedule expander. Loads one 16-word block
// into a sliding window and streams W_0..W_{NumRounds-1}, one word per handshake.
// Optional build macro: SHA2_SCHED_BLKCNT_EN adds the blk_cnt_o completed-block counter.
module sha2_msg_schedule
  import sha2_pkg::*;
#(
  parameter int WordWidth = 32,
  parameter int NumRounds = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic [16*WordWidth-1:0]      blk_i,
  input  logic                         blk_valid_i,
  output logic                         blk_ready_o,
  output logic [WordWidth-1:0]         w_o,
  output logic [$clog2(NumRounds)-1:0] w_idx_o,
  output logic                         w_last_o,
  output logic                         w_valid_o,
  input  logic                         w_ready_i
`ifdef SHA2_SCHED_BLKCNT_EN
  ,
  output logic [31:0]                  blk_cnt_o
`endif
);

  localparam int IdxW = $clog2(NumRounds);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRounds - 1);

  sched_state_e         state_r, state_s;
  logic [WordWidth-1:0] win_r [16];
  logic [IdxW-1:0]      t_r;
  logic [WordWidth-1:0] sig0_s, sig1_s, next_word_s;
  logic                 last_s, blk_fire_s, w_fire_s;

  // s0 taps the word after the current one, s1 the word two before the window end
  sha2_small_sigma #(.WordWidth(WordWidth), .Sel(0)) u_sigma0 (
    .x_i (win_r[1]),
    .y_o (sig0_s)
  );

  sha2_small_sigma #(.WordWidth(WordWidth), .Sel(1)) u_sigma1 (
    .x_i (win_r[14]),
    .y_o (sig1_s)
  );

  assign next_word_s = sig1_s + win_r[9] + sig0_s + win_r[0];
  assign last_s      = (t_r == LastIdx);

  // clear_i cancels any handshake that coincides with it
  assign blk_fire_s  = blk_valid_i & blk_ready_o & ~clear_i;
  assign w_fire_s    = w_valid_o & w_ready_i & ~clear_i;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= SchedIdle;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: clear wins, otherwise load on block, leave after last word
  always_comb begin
    state_s = state_r;
    if (clear_i) begin
      state_s = SchedIdle;
    end else begin
      case (state_r)
        SchedIdle: begin
          if (blk_valid_i) state_s = SchedRun;
          else             state_s = SchedIdle;
        end
        SchedRun: begin
          if (w_ready_i && last_s) state_s = SchedIdle;
          else                     state_s = SchedRun;
        end
        default: state_s = SchedIdle;
      endcase
    end
  end

  // FSM outputs: ready for a block only when idle, word valid only when running
  always_comb begin
    blk_ready_o = 1'b0;
    w_valid_o   = 1'b0;
    case (state_r)
      SchedIdle: begin
        blk_ready_o = 1'b1;
        w_valid_o   = 1'b0;
      end
      SchedRun: begin
        blk_ready_o = 1'b0;
        w_valid_o   = 1'b1;
      end
      default: begin
        blk_ready_o = 1'b1;
        w_valid_o   = 1'b0;
      end
    endcase
  end

  // Sliding window: load block big-endian, shift in the expanded word per handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) win_r[i] <= '0;
    end else if (blk_fire_s) begin
      for (int i = 0; i < 16; i++) win_r[i] <= blk_i[(16-i)*WordWidth-1 -: WordWidth];
    end else if (w_fire_s) begin
      for (int i = 0; i < 15; i++) win_r[i] <= win_r[i+1];
      win_r[15] <= next_word_s;
    end else begin
      for (int i = 0; i < 16; i++) win_r[i] <= win_r[i];
    end
  end

  // Round index: restarts on clear or new block, wraps to zero after the last word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_r <= '0;
    end else if (clear_i || blk_fire_s) begin
      t_r <= '0;
    end else if (w_fire_s) begin
      t_r <= last_s ? '0 : t_r + IdxW'(1);
    end else begin
      t_r <= t_r;
    end
  end

  assign w_o      = win_r[0];
  assign w_idx_o  = t_r;
  assign w_last_o = last_s & (state_r == SchedRun);

`ifdef SHA2_SCHED_BLKCNT_EN
  logic [31:0] blk_cnt_r;

  // Completed-block counter: reset only by rst_ni, wraps naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_cnt_r <= 32'd0;
    end else if (w_fire_s && last_s) begin
      blk_cnt_r <= blk_cnt_r + 32'd1;
    end else begin
      blk_cnt_r <= blk_cnt_r;
    end
  end

  assign blk_cnt_o = blk_cnt_r;
`endif

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// tb_sha2_msg_schedule: self-checking bench for the SHA-2 message schedule.
// Runs a 32-bit and a 64-bit instance against an array-based reference model.
module tb_sha2_msg_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clear, w_ready, blk_valid;
  logic          sel64;
  logic [511:0]  blk32;
  logic [1023:0] blk64;

  logic          ready32, valid32, last32;
  logic [31:0]   w32;
  logic [5:0]    idx32;
  logic          ready64, valid64, last64;
  logic [63:0]   w64;
  logic [6:0]    idx64;
`ifdef SHA2_SCHED_BLKCNT_EN
  logic [31:0]   cnt32, cnt64;
`endif

  sha2_msg_schedule #(.WordWidth(32), .NumRounds(64)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .blk_i(blk32), .blk_valid_i(blk_valid & ~sel64), .blk_ready_o(ready32),
    .w_o(w32), .w_idx_o(idx32), .w_last_o(last32), .w_valid_o(valid32),
    .w_ready_i(w_ready)
`ifdef SHA2_SCHED_BLKCNT_EN
    , .blk_cnt_o(cnt32)
`endif
  );

  sha2_msg_schedule #(.WordWidth(64), .NumRounds(80)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .blk_i(blk64), .blk_valid_i(blk_valid & sel64), .blk_ready_o(ready64),
    .w_o(w64), .w_idx_o(idx64), .w_last_o(last64), .w_valid_o(valid64),
    .w_ready_i(w_ready)
`ifdef SHA2_SCHED_BLKCNT_EN
    , .blk_cnt_o(cnt64)
`endif
  );

  // Observed outputs of whichever instance is under test
  logic        o_ready, o_valid, o_last;
  logic [63:0] o_w;
  logic [6:0]  o_idx;
  assign o_ready = sel64 ? ready64 : ready32;
  assign o_valid = sel64 ? valid64 : valid32;
  assign o_last  = sel64 ? last64  : last32;
  assign o_w     = sel64 ? w64     : {32'd0, w32};
  assign o_idx   = sel64 ? idx64   : {1'b0, idx32};

  int checks = 0;
  int errors = 0;

  logic [63:0] ref_w [80];
  logic [63:0] got_w [80];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: full-array SHA-2 expansion ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input logic w64);
    logic [31:0] y;
    if (w64) return (x >> n) | (x << (64 - n));
    y = x[31:0];
    return {32'd0, (y >> n) | (y << (32 - n))};
  endfunction

  function automatic logic [63:0] ss0(input logic [63:0] x, input logic w64);
    if (w64) return rotr(x, 1, 1'b1) ^ rotr(x, 8, 1'b1) ^ (x >> 7);
    return rotr(x, 7, 1'b0) ^ rotr(x, 18, 1'b0) ^ {32'd0, x[31:0] >> 3};
  endfunction

  function automatic logic [63:0] ss1(input logic [63:0] x, input logic w64);
    if (w64) return rotr(x, 19, 1'b1) ^ rotr(x, 61, 1'b1) ^ (x >> 6);
    return rotr(x, 17, 1'b0) ^ rotr(x, 19, 1'b0) ^ {32'd0, x[31:0] >> 10};
  endfunction

  task automatic build_ref(input logic [1023:0] blk, input logic w64);
    int nr;
    logic [63:0] sum;
    nr = w64 ? 80 : 64;
    for (int t = 0; t < 16; t++)
      ref_w[t] = w64 ? blk[1023-64*t -: 64] : {32'd0, blk[511-32*t -: 32]};
    for (int t = 16; t < nr; t++) begin
      sum = ss1(ref_w[t-2], w64) + ref_w[t-7] + ss0(ref_w[t-15], w64) + ref_w[t-16];
      ref_w[t] = w64 ? sum : {32'd0, sum[31:0]};
    end
  endtask

  // ---------------- stimulus ----------------
  // Called at a falling edge with the DUT idle; returns at a falling edge with it idle.
  task automatic run_block(input logic [1023:0] blk, input int rdy_pct,
                           input int clear_at, input int rst_at);
    int nr, t, budget;
    logic rdy;
    nr = sel64 ? 80 : 64;
    t = 0;
    budget = 0;
    build_ref(blk, sel64);
    chk("blk_ready_idle", 64'(o_ready), 64'd1);
    if (sel64) blk64 = blk; else blk32 = blk[511:0];
    blk_valid = 1'b1;
    @(negedge clk);
    while (t < nr) begin
      budget++;
      if (budget > 1000) begin
        checks++;
        errors++;
        $display("FAIL timeout actual_t=%0d required_t=%0d", t, nr);
        break;
      end
      got_w[t] = o_w;
      chk("w_valid", 64'(o_valid), 64'd1);
      chk("w_o", o_w, ref_w[t]);
      chk("w_idx", 64'(o_idx), 64'(t));
      chk("w_last", 64'(o_last), 64'(t == nr - 1));
      chk("blk_ready_run", 64'(o_ready), 64'd0);
      if (t == clear_at) begin
        clear = 1'b1;
        w_ready = 1'b1;
        blk_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_valid", 64'(o_valid), 64'd0);
        chk("clr_ready", 64'(o_ready), 64'd1);
        chk("clr_idx", 64'(o_idx), 64'd0);
        return;
      end
      if (t == rst_at) begin
        blk_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_ready", 64'(o_ready), 64'd1);
        chk("arst_w", o_w, 64'd0);
        chk("arst_idx", 64'(o_idx), 64'd0);
        chk("arst_last", 64'(o_last), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      rdy = ($urandom_range(99) < rdy_pct);
      w_ready = rdy;
      // a block offered while running must be ignored
      blk_valid = (t < nr - 1) ? 1'($urandom_range(1)) : 1'b0;
      blk32 = ~blk32;
      blk64 = ~blk64;
      @(negedge clk);
      if (rdy) t++;
    end
    blk_valid = 1'b0;
    chk("end_valid", 64'(o_valid), 64'd0);
    chk("end_ready", 64'(o_ready), 64'd1);
  endtask

  function automatic logic [1023:0] rand_blk(input logic w64);
    logic [1023:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) b[32*i +: 32] = $urandom;
    if (!w64) b[1023:512] = '0;
    return b;
  endfunction

  typedef struct {
    logic [511:0] blk;
    logic [31:0]  w16;
    logic [31:0]  w17;
  } vec_t;

  vec_t vecs [6];
  logic [1023:0] abc_blk;

  initial begin
    vecs[0] = '{512'd0, 32'h00000000, 32'h00000000};
    vecs[1] = '{{32'h61626380, 448'd0, 32'h00000018}, 32'h61626380, 32'h000F0000};
    vecs[2] = '{{32'h00000001, 480'd0}, 32'h00000001, 32'h00000000};
    vecs[3] = '{{32'd0, 32'h00000001, 448'd0}, 32'h02004000, 32'h00000001};
    vecs[4] = '{{480'd0, 32'h00000001}, 32'h00000000, 32'h0000A000};
    vecs[5] = '{{288'd0, 32'h00000005, 192'd0}, 32'h00000005, 32'h00000000};
    abc_blk = {512'd0, vecs[1].blk};

    rst_n = 1'b0; clear = 1'b0; w_ready = 1'b0; blk_valid = 1'b0;
    sel64 = 1'b0; blk32 = '0; blk64 = '0;

    // reset values on both instances
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel64 = 1'(s);
      #1;
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_w", o_w, 64'd0);
      chk("rst_idx", 64'(o_idx), 64'd0);
      chk("rst_last", 64'(o_last), 64'd0);
    end
    sel64 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // known vectors incl. "abc", full stream at ready=1
    for (int v = 0; v < 6; v++) begin
      run_block({512'd0, vecs[v].blk}, 100, -1, -1);
      chk("vec_w16", got_w[16], {32'd0, vecs[v].w16});
      chk("vec_w17", got_w[17], {32'd0, vecs[v].w17});
    end

    // three back-to-back random blocks with 50% consumer stalls
    for (int b = 0; b < 3; b++) run_block(rand_blk(1'b0), 50, -1, -1);

    // abort at t=20, then next block restarts at W_0
    run_block(rand_blk(1'b0), 100, 20, -1);
    run_block(abc_blk, 100, -1, -1);

    // asynchronous reset at t=40, then rerun
    run_block(abc_blk, 100, -1, 40);
    run_block(abc_blk, 70, -1, -1);

    // 64-bit instance: all-ones block, then a random one with stalls
    sel64 = 1'b1;
    @(negedge clk);
    run_block({1024{1'b1}}, 100, -1, -1);
    run_block(rand_blk(1'b1), 50, -1, -1);
    sel64 = 1'b0;
    @(negedge clk);

`ifdef SHA2_SCHED_BLKCNT_EN
    // counter: 5 blocks, third aborted; clear does not reset the count
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("cnt_rst", 64'(cnt32), 64'd0);
    @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      run_block(rand_blk(1'b0), 80, (b == 2) ? 20 : -1, -1);
      if (b == 2) chk("cnt_after_clear", 64'(cnt32), 64'd2);
    end
    chk("cnt_final", 64'(cnt32), 64'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
